// File: rtl/id_stage.sv
// id_stage: instruction decode for the AZ core. It contains the opcode decoder,
// operand forwarding, load-use hazard detection and branch resolution.
// It also holds the registered ID/EX pipeline register, which supports stall,
// flush and bubble insertion.
module id_stage #(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 30,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_N      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PC_W-1:0]             if_pc,
  input  logic [31:0]                 if_insn,
  input  logic                        if_en,
  input  logic                        stall,
  input  logic                        flush,
  output logic [REG_ADDR_W-1:0]       gpr_raddr_0,
  output logic [REG_ADDR_W-1:0]       gpr_raddr_1,
  input  logic [DATA_W-1:0]           gpr_rdata_0,
  input  logic [DATA_W-1:0]           gpr_rdata_1,
  output logic [REG_ADDR_W-1:0]       creg_rd_addr,
  input  logic [DATA_W-1:0]           creg_rd_data,
  input  logic                        exe_mode,
  input  logic [FWD_N-1:0]            fwd_en,
  input  logic [FWD_N-1:0]            fwd_wen,
  input  logic [FWD_N*REG_ADDR_W-1:0] fwd_addr,
  input  logic [FWD_N*DATA_W-1:0]     fwd_data,
  input  logic                        fwd_is_ld,
  output logic                        ld_hazard,
  output logic                        br_taken,
  output logic [PC_W-1:0]             br_addr,
  output logic [PC_W-1:0]             id_pc,
  output logic                        id_en,
  output logic [3:0]                  id_alu_op,
  output logic [DATA_W-1:0]           id_alu_in_0,
  output logic [DATA_W-1:0]           id_alu_in_1,
  output logic                        id_br_flag,
  output logic [1:0]                  id_mem_op,
  output logic [DATA_W-1:0]           id_mem_wdata,
  output logic [1:0]                  id_ctrl_op,
  output logic [REG_ADDR_W-1:0]       id_dst_addr,
  output logic                        id_gpr_wen,
  output logic [2:0]                  id_exp_code
);

  localparam logic [3:0] ALU_NOP = 4'd0, ALU_AND = 4'd1, ALU_OR = 4'd2, ALU_XOR = 4'd3,
                         ALU_ADDS = 4'd4, ALU_ADDU = 4'd5, ALU_SUBS = 4'd6,
                         ALU_SUBU = 4'd7, ALU_SHRL = 4'd8, ALU_SHLL = 4'd9;

  logic [5:0]            op;
  logic [REG_ADDR_W-1:0] ra_addr, rb_addr, rc_addr;
  logic [15:0]           imm;
  logic [DATA_W-1:0]     imm_s, imm_u;
  logic [DATA_W-1:0]     ra_data, rb_data;

  // decoded (pre-register) fields
  logic [3:0]            dec_alu_op;
  logic [DATA_W-1:0]     dec_alu_in_0, dec_alu_in_1;
  logic                  dec_br_flag, dec_br_cond;
  logic [PC_W-1:0]       dec_br_addr;
  logic [1:0]            dec_mem_op, dec_ctrl_op;
  logic [REG_ADDR_W-1:0] dec_dst;
  logic                  dec_gpr_wen;
  logic [2:0]            dec_exp_code;

  // ID/EX register state
  logic [PC_W-1:0]       id_pc_q, id_pc_d;
  logic                  id_en_q, id_en_d;
  logic [3:0]            id_alu_op_q, id_alu_op_d;
  logic [DATA_W-1:0]     id_alu_in_0_q, id_alu_in_0_d;
  logic [DATA_W-1:0]     id_alu_in_1_q, id_alu_in_1_d;
  logic                  id_br_flag_q, id_br_flag_d;
  logic [1:0]            id_mem_op_q, id_mem_op_d;
  logic [DATA_W-1:0]     id_mem_wdata_q, id_mem_wdata_d;
  logic [1:0]            id_ctrl_op_q, id_ctrl_op_d;
  logic [REG_ADDR_W-1:0] id_dst_addr_q, id_dst_addr_d;
  logic                  id_gpr_wen_q, id_gpr_wen_d;
  logic [2:0]            id_exp_code_q, id_exp_code_d;

  assign op      = if_insn[31:26];
  assign ra_addr = REG_ADDR_W'(if_insn[25:21]);
  assign rb_addr = REG_ADDR_W'(if_insn[20:16]);
  assign rc_addr = REG_ADDR_W'(if_insn[15:11]);
  assign imm     = if_insn[15:0];
  assign imm_s   = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_u   = {{(DATA_W-16){1'b0}}, imm};

  assign gpr_raddr_0  = ra_addr;
  assign gpr_raddr_1  = rb_addr;
  assign creg_rd_addr = ra_addr;

  // Operand forwarding: walk from oldest to youngest so the lowest matching index wins.
  // A load in source 0 has no data yet, so it never forwards.
  always_comb begin
    ra_data = gpr_rdata_0;
    rb_data = gpr_rdata_1;
    for (int i = FWD_N - 1; i >= 0; i--) begin
      if (fwd_en[i] && fwd_wen[i] && !(i == 0 && fwd_is_ld)) begin
        if (fwd_addr[i*REG_ADDR_W +: REG_ADDR_W] == ra_addr) ra_data = fwd_data[i*DATA_W +: DATA_W];
        if (fwd_addr[i*REG_ADDR_W +: REG_ADDR_W] == rb_addr) rb_data = fwd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Load-use hazard: the youngest stage is a load that writes one of our operands.
  assign ld_hazard = if_en & fwd_en[0] & fwd_is_ld &
                     ((fwd_addr[REG_ADDR_W-1:0] == ra_addr) | (fwd_addr[REG_ADDR_W-1:0] == rb_addr));

  // Opcode decoder: ALU controls, operands, destination, memory/control ops, branches, exceptions.
  always_comb begin
    dec_alu_op   = ALU_NOP;
    dec_alu_in_0 = ra_data;
    dec_alu_in_1 = rb_data;
    dec_br_flag  = 1'b0;
    dec_br_cond  = 1'b0;
    dec_br_addr  = if_pc + imm_s[PC_W-1:0];
    dec_mem_op   = 2'd0;
    dec_ctrl_op  = 2'd0;
    dec_dst      = rb_addr;
    dec_gpr_wen  = 1'b0;
    dec_exp_code = 3'd0;
    case (op)
      6'h00, 6'h01: dec_alu_op = ALU_AND;
      6'h02, 6'h03: dec_alu_op = ALU_OR;
      6'h04, 6'h05: dec_alu_op = ALU_XOR;
      6'h06, 6'h07: dec_alu_op = ALU_ADDS;
      6'h08, 6'h09: dec_alu_op = ALU_ADDU;
      6'h0A:        dec_alu_op = ALU_SUBS;
      6'h0B:        dec_alu_op = ALU_SUBU;
      6'h0C, 6'h0D: dec_alu_op = ALU_SHRL;
      6'h0E, 6'h0F: dec_alu_op = ALU_SHLL;
      6'h10: begin dec_br_flag = 1'b1; dec_br_cond = (ra_data == rb_data); end
      6'h11: begin dec_br_flag = 1'b1; dec_br_cond = (ra_data != rb_data); end
      6'h12: begin dec_br_flag = 1'b1; dec_br_cond = ($signed(ra_data) < $signed(rb_data)); end
      6'h13: begin dec_br_flag = 1'b1; dec_br_cond = (ra_data < rb_data); end
      6'h14: begin
        dec_br_flag = 1'b1;
        dec_br_cond = 1'b1;
        dec_br_addr = ra_data[PC_W+1:2];
      end
      6'h15: begin
        dec_br_flag  = 1'b1;
        dec_br_cond  = 1'b1;
        dec_br_addr  = ra_data[PC_W+1:2];
        dec_alu_in_0 = DATA_W'({if_pc + PC_W'(1), 2'b00});
        dec_dst      = rc_addr;
        dec_gpr_wen  = 1'b1;
      end
      6'h16: begin
        dec_alu_op   = ALU_ADDU;
        dec_alu_in_1 = imm_s;
        dec_mem_op   = 2'd1;
        dec_gpr_wen  = 1'b1;
      end
      6'h17: begin
        dec_alu_op   = ALU_ADDU;
        dec_alu_in_1 = imm_s;
        dec_mem_op   = 2'd2;
      end
      6'h18: dec_exp_code = 3'd5;
      6'h19: begin
        dec_alu_in_0 = creg_rd_data;
        if (!exe_mode) dec_gpr_wen = 1'b1;
        else           dec_exp_code = 3'd6;
      end
      6'h1A: begin
        if (!exe_mode) dec_ctrl_op = 2'd1;
        else           dec_exp_code = 3'd6;
      end
      6'h1B: begin
        if (!exe_mode) dec_ctrl_op = 2'd2;
        else           dec_exp_code = 3'd6;
      end
      default: dec_exp_code = 3'd2;
    endcase
    // ALU group: even opcodes and the two subtracts are register forms
    if (op <= 6'h0F) begin
      dec_gpr_wen = 1'b1;
      if (!op[0] || op == 6'h0B) dec_dst = rc_addr;
      else if (op == 6'h07)       dec_alu_in_1 = imm_s;
      else                        dec_alu_in_1 = imm_u;
    end
  end

  assign br_taken = if_en & ~ld_hazard & dec_br_cond;
  assign br_addr  = dec_br_addr;

  // ID/EX next state: flush, then stall, then load-use bubble, then normal issue.
  always_comb begin
    id_pc_d        = id_pc_q;
    id_en_d        = id_en_q;
    id_alu_op_d    = id_alu_op_q;
    id_alu_in_0_d  = id_alu_in_0_q;
    id_alu_in_1_d  = id_alu_in_1_q;
    id_br_flag_d   = id_br_flag_q;
    id_mem_op_d    = id_mem_op_q;
    id_mem_wdata_d = id_mem_wdata_q;
    id_ctrl_op_d   = id_ctrl_op_q;
    id_dst_addr_d  = id_dst_addr_q;
    id_gpr_wen_d   = id_gpr_wen_q;
    id_exp_code_d  = id_exp_code_q;
    if (flush || (!stall && ld_hazard)) begin
      id_en_d       = 1'b0;
      id_gpr_wen_d  = 1'b0;
      id_mem_op_d   = 2'd0;
      id_ctrl_op_d  = 2'd0;
      id_br_flag_d  = 1'b0;
      id_exp_code_d = 3'd0;
    end else if (!stall) begin
      id_pc_d        = if_pc;
      id_en_d        = if_en;
      id_alu_op_d    = dec_alu_op;
      id_alu_in_0_d  = dec_alu_in_0;
      id_alu_in_1_d  = dec_alu_in_1;
      id_mem_wdata_d = rb_data;
      id_dst_addr_d  = dec_dst;
      // an empty slot must not write, access memory or trap
      id_br_flag_d   = if_en & dec_br_flag;
      id_mem_op_d    = if_en ? dec_mem_op : 2'd0;
      id_ctrl_op_d   = if_en ? dec_ctrl_op : 2'd0;
      id_gpr_wen_d   = if_en & dec_gpr_wen;
      id_exp_code_d  = if_en ? dec_exp_code : 3'd0;
    end
  end

  // ID/EX register with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_pc_q        <= '0;
      id_en_q        <= 1'b0;
      id_alu_op_q    <= '0;
      id_alu_in_0_q  <= '0;
      id_alu_in_1_q  <= '0;
      id_br_flag_q   <= 1'b0;
      id_mem_op_q    <= '0;
      id_mem_wdata_q <= '0;
      id_ctrl_op_q   <= '0;
      id_dst_addr_q  <= '0;
      id_gpr_wen_q   <= 1'b0;
      id_exp_code_q  <= '0;
    end else begin
      id_pc_q        <= id_pc_d;
      id_en_q        <= id_en_d;
      id_alu_op_q    <= id_alu_op_d;
      id_alu_in_0_q  <= id_alu_in_0_d;
      id_alu_in_1_q  <= id_alu_in_1_d;
      id_br_flag_q   <= id_br_flag_d;
      id_mem_op_q    <= id_mem_op_d;
      id_mem_wdata_q <= id_mem_wdata_d;
      id_ctrl_op_q   <= id_ctrl_op_d;
      id_dst_addr_q  <= id_dst_addr_d;
      id_gpr_wen_q   <= id_gpr_wen_d;
      id_exp_code_q  <= id_exp_code_d;
    end
  end

  assign id_pc        = id_pc_q;
  assign id_en        = id_en_q;
  assign id_alu_op    = id_alu_op_q;
  assign id_alu_in_0  = id_alu_in_0_q;
  assign id_alu_in_1  = id_alu_in_1_q;
  assign id_br_flag   = id_br_flag_q;
  assign id_mem_op    = id_mem_op_q;
  assign id_mem_wdata = id_mem_wdata_q;
  assign id_ctrl_op   = id_ctrl_op_q;
  assign id_dst_addr  = id_dst_addr_q;
  assign id_gpr_wen   = id_gpr_wen_q;
  assign id_exp_code  = id_exp_code_q;

endmodule
